sound_request_ctrl: RTL
=======================

Name: sound_request_ctrl

Overview:
Upstream sequencer for the song player. It converts one-cycle guess-result events from the game logic into a timed, level-type play request and a song select (win/lose tune).
- Enforces a fixed play window, then a silent gap so the player restarts at note 0.
- Queues at most one pending request.
- Sits between the guess comparator and the player's playSound/val inputs.

Parameters:
CLK_FREQ, 100_000_000, clock frequency in Hz; TPM = CLK_FREQ/1000 clocks per ms (integer division, must be >= 1)
PLAY_MS, 2000, play window length in ms (>= 1)
GAP_MS, 200, silent gap after each play in ms (>= 1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
guess_valid  input  1  one-cycle pulse: a guess result is available
guess_correct  input  1  result qualifier, sampled with guess_valid (1 = win song)
mute  input  1  level; suppresses all sound
play_sound  output  1  level request to the player; high only in PLAY
song_sel  output  1  song select to the player; stable throughout PLAY
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse on normal completion of a play window

Behaviour:
- Reset (async): state=IDLE; play_sound=0, song_sel=0, busy=0, done=0; ms prescaler, ms counter and pending valid/select cleared. Reset mid-PLAY drops play_sound in the same cycle.
- All outputs are registered.
  - play_sound == (state==PLAY).
  - busy == (state!=IDLE).
- Timing: prescaler counts 0..TPM-1; ms counter increments on prescaler wrap. Both clear on every state entry.
  - PLAY lasts exactly PLAY_MS*TPM cycles.
  - GAP lasts exactly GAP_MS*TPM cycles.
  - Counter widths are sized by $clog2 from the parameters. No wrap is possible inside a state.
- IDLE:
  - guess_valid=1 and mute=0 at edge k: next state PLAY, song_sel<=guess_correct. play_sound is high from the cycle after edge k.
  - guess_valid while mute=1 is discarded.
- PLAY:
  - On the last cycle: next state GAP, done=1 for exactly one cycle (the first GAP cycle), play_sound=0.
  - mute=1 in any PLAY cycle: abort to GAP next cycle. No done pulse; pending cleared.
- GAP (play_sound=0 so the player resets its note index):
  - On the last cycle, if a pending request exists or guess_valid=1 (mute=0): go to PLAY with no idle cycle, pending cleared.
    - song_sel takes the newest value; a same-cycle guess_valid overrides pending.
  - Otherwise go to IDLE.
- Pending register (1 entry) during PLAY and GAP:
  - guess_valid with mute=0 sets pending and stores guess_correct.
  - A second request overwrites the first (newest wins).
- song_sel changes only on entry to PLAY. It holds its value through GAP and IDLE.
- Simultaneous cases:
  - guess_valid on the last PLAY cycle: goes to pending.
  - mute and guess_valid in the same cycle: mute wins.

Optional Feature:
SOUND_REQ_DROP_CNT_EN
- Defined: adds output drop_count [7:0], an 8-bit saturating count (stops at 255) of requests lost. A request counts as lost when either:
  - it overwrites a valid pending entry, or
  - it arrives while mute=1.
  Reset value 0.
- Undefined: no port, no counter. All other behaviour is identical.

Test Plan:
1. Params CLK_FREQ=4000, PLAY_MS=5, GAP_MS=2 (TPM=4). guess_valid=1, guess_correct=1 at edge 10 -> play_sound high cycles 11..30 (20 cycles), song_sel=1, done pulse at cycle 31, busy low from cycle 39.
2. Same params. Requests at edge 10 (correct=0), edge 15 (correct=1), edge 20 (correct=0) -> first play song_sel=0. Second play starts at cycle 39 with song_sel=0 (the edge-20 request overwrote edge-15); drop_count=1 if the macro is defined.
3. mute=1 at cycle 18 during PLAY -> play_sound=0 at cycle 19, no done pulse, GAP of 8 cycles, then IDLE with no replay.
4. guess_valid on the last GAP cycle with pending correct=1 and new correct=0 -> PLAY begins the next cycle with song_sel=0 and no IDLE cycle.
5. Assert reset at cycle 20 mid-PLAY -> play_sound, busy, song_sel, done all 0 immediately. After release, the first guess_valid gives a full 20-cycle play.
6. mute held high, 300 guess_valid pulses -> play_sound never asserts. With the macro defined, drop_count saturates at 255.

Source files
------------

// File: rtl/sound_request_ctrl.sv
// sound_request_ctrl
// Turns one-cycle guess-result events into a timed, level-type play request
// plus a win/lose song select for the song player. Each play window is
// followed by a silent gap so the player restarts from its first note. While
// a play or gap is running, one further request can be held as pending; a
// newer request replaces an older one.
//
// Optional build macro: SOUND_REQ_DROP_CNT_EN
//   When defined, adds drop_count[7:0]. This is a saturating count of lost
//   requests: a request is lost if it overwrites a valid pending entry or if
//   it arrives while mute is high.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no sound, waiting for a guess result
// PLAY  | play_sound high for PLAY_MS, song_sel held stable
// GAP   | play_sound low for GAP_MS so the player resets its note index
//
// Mute suppresses all sound. If mute is high on the last GAP cycle, a pending
// request is dropped instead of replayed, and the block returns to IDLE.

module sound_request_ctrl #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int PLAY_MS  = 2000,
    parameter int GAP_MS   = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       guess_valid,
    input  logic       guess_correct,
    input  logic       mute,
    output logic       play_sound,
    output logic       song_sel,
    output logic       busy,
`ifdef SOUND_REQ_DROP_CNT_EN
    output logic [7:0] drop_count,
`endif
    output logic       done
);

    localparam int TPM     = CLK_FREQ / 1000;
    localparam int PRESC_W = (TPM > 1) ? $clog2(TPM) : 1;
    localparam int MAX_MS  = (PLAY_MS > GAP_MS) ? PLAY_MS : GAP_MS;
    localparam int MS_W    = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TPM - 1);
    localparam logic [MS_W-1:0]    PLAY_LAST  = MS_W'(PLAY_MS - 1);
    localparam logic [MS_W-1:0]    GAP_LAST   = MS_W'(GAP_MS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [MS_W-1:0]    ms_q, ms_d;
    logic               pend_v_q, pend_v_d;
    logic               pend_s_q, pend_s_d;
    logic               play_sound_q, play_sound_d;
    logic               song_sel_q, song_sel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               req_ok;
    logic               presc_wrap;
    logic               play_last;
    logic               gap_last;

    // Qualified request and last-cycle detection for the current state.
    always_comb begin
        req_ok     = guess_valid & ~mute;
        presc_wrap = (presc_q == PRESC_LAST);
        play_last  = (state_q == ST_PLAY) && presc_wrap && (ms_q == PLAY_LAST);
        gap_last   = (state_q == ST_GAP) && presc_wrap && (ms_q == GAP_LAST);
    end

    // Next-state, pending-slot and registered-output computation.
    always_comb begin
        state_d    = state_q;
        pend_v_d   = pend_v_q;
        pend_s_d   = pend_s_q;
        song_sel_d = song_sel_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    state_d    = ST_PLAY;
                    song_sel_d = guess_correct;
                end
            end

            ST_PLAY: begin
                if (mute) begin
                    // An aborted play never signals done and forgets any queued replay.
                    state_d  = ST_GAP;
                    pend_v_d = 1'b0;
                end else begin
                    if (req_ok) begin
                        pend_v_d = 1'b1;
                        pend_s_d = guess_correct;
                    end
                    if (play_last) begin
                        state_d = ST_GAP;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (gap_last) begin
                    pend_v_d = 1'b0;
                    if (!mute && (req_ok || pend_v_q)) begin
                        state_d    = ST_PLAY;
                        song_sel_d = req_ok ? guess_correct : pend_s_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (req_ok) begin
                    pend_v_d = 1'b1;
                    pend_s_d = guess_correct;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                pend_v_d = 1'b0;
            end
        endcase

        play_sound_d = (state_d == ST_PLAY);
        busy_d       = (state_d != ST_IDLE);
    end

    // Millisecond prescaler and ms counter; both restart on every state entry.
    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (presc_wrap) begin
            presc_d = '0;
            ms_d    = ms_q + MS_W'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // State, timer and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            ms_q         <= '0;
            pend_v_q     <= 1'b0;
            pend_s_q     <= 1'b0;
            play_sound_q <= 1'b0;
            song_sel_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            ms_q         <= ms_d;
            pend_v_q     <= pend_v_d;
            pend_s_q     <= pend_s_d;
            play_sound_q <= play_sound_d;
            song_sel_q   <= song_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef SOUND_REQ_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;
    logic       lost;

    // Lost-request detection and saturating count.
    always_comb begin
        lost   = (guess_valid & mute) | (req_ok & pend_v_q & (state_q != ST_IDLE));
        drop_d = drop_q;
        if (lost && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

    assign play_sound = play_sound_q;
    assign song_sel   = song_sel_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
